// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundle of the fetch, debug and memory-side signals of the IMEM arbiter.
// Suffixes are from the arbiter's point of view.
// master: requester/memory environment (drives *_i, samples *_o)
// slave : the arbiter (samples *_i, drives *_o)
interface imem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_kill_i;
   logic              if_ack_o;
   logic [DATA_W-1:0] if_rdata_o;
   logic              dbg_req_i;
   logic              dbg_we_i;
   logic [ADDR_W-1:0] dbg_addr_i;
   logic [DATA_W-1:0] dbg_wdata_i;
   logic              dbg_ack_o;
   logic [DATA_W-1:0] dbg_rdata_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;
   modport master (
      output if_req_i, if_addr_i, if_kill_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
             mem_ack_i, mem_rdata_i,
      input  if_ack_o, if_rdata_o, dbg_ack_o, dbg_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
             mem_wdata_o
   );
   modport slave (
      input  if_req_i, if_addr_i, if_kill_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
             mem_ack_i, mem_rdata_i,
      output if_ack_o, if_rdata_o, dbg_ack_o, dbg_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
             mem_wdata_o
   );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares single-port IMEM between fetch and debug, one transaction outstanding.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - imem_arbiter_if.slave: fetch request/kill/ack, debug request/ack,
//           memory request/ack with read/write data
module imem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input logic          clk,
   input logic          rst_n,
   imem_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DBG, DRAIN} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     starve_q, starve_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              starved, grant_if, grant_dbg;
   always_comb begin
      starved   = starve_q == CW'(STARVE_MAX);
      // a fetch killed in the request cycle is never granted, which hands the slot to debug
      grant_if  = state_q == IDLE && bus.if_req_i && !bus.if_kill_i && !(bus.dbg_req_i && starved);
      grant_dbg = state_q == IDLE && bus.dbg_req_i && !grant_if;
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      if (grant_if) begin
         state_d = BUSY_IF;
         we_d    = 1'b0;
         addr_d  = bus.if_addr_i;
         wdata_d = '0;
      end else if (grant_dbg) begin
         state_d = BUSY_DBG;
         we_d    = bus.dbg_we_i;
         addr_d  = bus.dbg_addr_i;
         wdata_d = bus.dbg_wdata_i;
      end else if (state_q != IDLE && bus.mem_ack_i) begin
         state_d = IDLE;
      end else if (state_q == BUSY_IF && bus.if_kill_i) begin
         // the memory still owes an ack, so keep the request up and swallow it
         state_d = DRAIN;
      end
      starve_d = (!bus.dbg_req_i || grant_dbg) ? '0
               : (grant_if && !starved) ? starve_q + 1'b1
               : starve_q;
      req_d    = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         starve_q <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end
   assign bus.mem_req_o   = req_q;
   assign bus.mem_we_o    = we_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.if_ack_o    = bus.mem_ack_i && state_q == BUSY_IF && !bus.if_kill_i;
   assign bus.dbg_ack_o   = bus.mem_ack_i && state_q == BUSY_DBG;
   assign bus.if_rdata_o  = bus.if_ack_o ? bus.mem_rdata_i : '0;
   assign bus.dbg_rdata_o = bus.dbg_ack_o ? bus.mem_rdata_i : '0;
endmodule
